// File: rtl/drive_sequencer.sv
// Pad-drive sequencer: aligns pwm to the pattern buffer, inserts a programmable
// break-before-make dead time on every phase change, then steps a tweak pattern.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// st_off   | after reset, outputs off, waiting for the first phase edge
// st_dead  | dead-time count running, outputs off
// st_drive | p/n phase drive and tweak step pattern applied
module drive_sequencer #(
   parameter int buffer_width = 8,
   parameter int no_steps     = 8,
   parameter int delay_width  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    pwm,
   input  logic [buffer_width-1:0] p_drive,
   input  logic [buffer_width-1:0] n_drive,
   input  logic [buffer_width-1:0] tweak_delay,
   input  logic [buffer_width-1:0] tweak_sense,
   input  logic [buffer_width-1:0] tweak_drive_0,
   input  logic [buffer_width-1:0] tweak_drive_1,
   input  logic [buffer_width-1:0] tweak_drive_2,
   input  logic [buffer_width-1:0] tweak_drive_3,
   input  logic [buffer_width-1:0] tweak_drive_4,
   input  logic [buffer_width-1:0] tweak_drive_5,
   input  logic [buffer_width-1:0] tweak_drive_6,
   input  logic [buffer_width-1:0] tweak_drive_7,
   output logic [buffer_width-1:0] p_out,
   output logic [buffer_width-1:0] n_out,
   output logic [buffer_width-1:0] tweak_out,
   output logic [2:0]              step,
   output logic                    active
);

   localparam logic [2:0] last_step = 3'(no_steps - 1);

   typedef enum logic [1:0] {
      st_off,
      st_dead,
      st_drive
   } state_t;

   state_t                  state_q,     state_d;
   logic                    pwm_d1_q,    pwm_d1_d;
   logic                    pwm_d2_q,    pwm_d2_d;
   logic [delay_width-1:0]  dcnt_q,      dcnt_d;
   logic [2:0]              step_cnt_q,  step_cnt_d;
   logic [buffer_width-1:0] p_out_q,     p_out_d;
   logic [buffer_width-1:0] n_out_q,     n_out_d;
   logic [buffer_width-1:0] tweak_out_q, tweak_out_d;
   logic [2:0]              step_out_q,  step_out_d;
   logic                    active_q,    active_d;

   logic                    edge_det;
   logic                    drive_on;
   logic [delay_width-1:0]  delay_cap;
   logic [buffer_width-1:0] tweak_word;

   always_comb begin
      pwm_d1_d   = pwm;
      pwm_d2_d   = pwm_d1_q;
      edge_det   = (pwm_d1_q != pwm_d2_q);
      delay_cap  = tweak_delay[delay_width-1:0];
      state_d    = state_q;
      dcnt_d     = dcnt_q;
      step_cnt_d = step_cnt_q;

      // A phase edge restarts the sequence from any state.
      if (edge_det) begin
         dcnt_d     = delay_cap;
         step_cnt_d = 3'd0;
         state_d    = (delay_cap != '0) ? st_dead : st_drive;
      end else begin
         case (state_q)
            st_dead: begin
               if (dcnt_q <= delay_width'(1)) begin
                  dcnt_d  = '0;
                  state_d = st_drive;
               end else begin
                  dcnt_d = dcnt_q - delay_width'(1);
               end
            end
            st_drive: begin
               if (step_cnt_q != last_step) step_cnt_d = step_cnt_q + 3'd1;
            end
            default: ;
         endcase
      end

      case (step_cnt_q)
         3'd0:    tweak_word = tweak_drive_0;
         3'd1:    tweak_word = tweak_drive_1;
         3'd2:    tweak_word = tweak_drive_2;
         3'd3:    tweak_word = tweak_drive_3;
         3'd4:    tweak_word = tweak_drive_4;
         3'd5:    tweak_word = tweak_drive_5;
         3'd6:    tweak_word = tweak_drive_6;
         default: tweak_word = tweak_drive_7;
      endcase

      // Gating p on phase 1 and n on phase 0 is what prevents shoot-through.
      drive_on    = (state_q == st_drive) && enable;
      p_out_d     = (drive_on &&  pwm_d2_q) ? p_drive : '1;
      n_out_d     = (drive_on && !pwm_d2_q) ? n_drive : '0;
      tweak_out_d = drive_on ? (tweak_word & tweak_sense) : '0;
      step_out_d  = step_cnt_q;
      active_d    = drive_on;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= st_off;
         pwm_d1_q    <= 1'b0;
         pwm_d2_q    <= 1'b0;
         dcnt_q      <= '0;
         step_cnt_q  <= 3'd0;
         p_out_q     <= '1;
         n_out_q     <= '0;
         tweak_out_q <= '0;
         step_out_q  <= 3'd0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pwm_d1_q    <= pwm_d1_d;
         pwm_d2_q    <= pwm_d2_d;
         dcnt_q      <= dcnt_d;
         step_cnt_q  <= step_cnt_d;
         p_out_q     <= p_out_d;
         n_out_q     <= n_out_d;
         tweak_out_q <= tweak_out_d;
         step_out_q  <= step_out_d;
         active_q    <= active_d;
      end
   end

   assign p_out     = p_out_q;
   assign n_out     = n_out_q;
   assign tweak_out = tweak_out_q;
   assign step      = step_out_q;
   assign active    = active_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: timeline model of the dead-time/step sequence,
// directed phase scenarios with literal checks, and a random shoot-through sweep.
module tb_drive_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       pwm;
   logic [7:0] p_drive, n_drive, tweak_delay, tweak_sense;
   logic [7:0] tw [8];
   logic [7:0] p_out, n_out, tweak_out;
   logic [2:0] step;
   logic       active;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   drive_sequencer dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pwm(pwm),
      .p_drive(p_drive), .n_drive(n_drive),
      .tweak_delay(tweak_delay), .tweak_sense(tweak_sense),
      .tweak_drive_0(tw[0]), .tweak_drive_1(tw[1]),
      .tweak_drive_2(tw[2]), .tweak_drive_3(tw[3]),
      .tweak_drive_4(tw[4]), .tweak_drive_5(tw[5]),
      .tweak_drive_6(tw[6]), .tweak_drive_7(tw[7]),
      .p_out(p_out), .n_out(n_out), .tweak_out(tweak_out),
      .step(step), .active(active)
   );

   // Model: remember the last phase edge and its captured delay; the output
   // at any clock follows from how many clocks have passed since that edge.
   logic       m_d1, m_d2, have_edge;
   int         age, m_delay;
   logic [7:0] e_p, e_n, e_t;
   logic [2:0] e_step;
   logic       e_act;
   bit         model_valid = 0;

   always @(posedge clk) begin : model
      int   k;
      logic on;
      if (!rst_n) begin
         m_d1 = 0; m_d2 = 0; have_edge = 0; age = 0; m_delay = 0;
         e_p = 8'hFF; e_n = 8'h00; e_t = 8'h00; e_step = 3'd0; e_act = 0;
         model_valid = 1;
      end else begin
         if (have_edge && age < 100000) age++;
         k      = age - 1 - m_delay;
         on     = have_edge && (k >= 0);
         e_step = !on ? 3'd0 : (k > 7) ? 3'd7 : 3'(k);
         e_act  = on && enable;
         e_p    = (e_act && m_d2)  ? p_drive : 8'hFF;
         e_n    = (e_act && !m_d2) ? n_drive : 8'h00;
         e_t    = e_act ? (tw[e_step] & tweak_sense) : 8'h00;
         if (m_d1 != m_d2) begin
            have_edge = 1; age = 0; m_delay = int'(tweak_delay);
         end
         m_d2 = m_d1;
         m_d1 = pwm;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         vectors++;
         if ({p_out, n_out, tweak_out, step, active} !== {e_p, e_n, e_t, e_step, e_act}) begin
            miscompares++;
            $display("FAIL model t=%0t p=%h/%h n=%h/%h tweak=%h/%h step=%0d/%0d active=%b/%b (got/required)",
                     $time, p_out, e_p, n_out, e_n, tweak_out, e_t, step, e_step, active, e_act);
         end
         vectors++;
         if ((~p_out & n_out) !== 8'h00) begin
            miscompares++;
            $display("FAIL shoot_through t=%0t p=%h n=%h overlap=%h required 00",
                     $time, p_out, n_out, ~p_out & n_out);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // Toggle pwm to lvl and check the off window of d clocks and step-0 arrival.
   task automatic edge_to(input logic lvl, input int d, input string nm);
      pwm = lvl;
      tick();
      tick();
      for (int i = 0; i < d; i++) begin
         tick();
         chk({nm, " off active"}, {7'd0, active}, 8'h00);
         chk({nm, " off p"}, p_out, 8'hFF);
      end
      tick();
      chk({nm, " on active"}, {7'd0, active}, 8'h01);
      chk({nm, " on step"}, {5'd0, step}, 8'h00);
   endtask

   initial begin
      rst_n = 0; enable = 1; pwm = 0;
      p_drive = 0; n_drive = 0; tweak_delay = 0; tweak_sense = 0;
      for (int i = 0; i < 8; i++) tw[i] = 0;

      for (int c = 0; c < 3; c++) begin
         pwm = 1'($urandom); enable = 1'($urandom);
         p_drive = 8'($urandom); n_drive = 8'($urandom);
         tweak_delay = 8'($urandom); tweak_sense = 8'($urandom);
         for (int i = 0; i < 8; i++) tw[i] = 8'($urandom);
         tick();
         chk("reset p_out", p_out, 8'hFF);
         chk("reset n_out", n_out, 8'h00);
         chk("reset tweak_out", tweak_out, 8'h00);
         chk("reset step", {5'd0, step}, 8'h00);
         chk("reset active", {7'd0, active}, 8'h00);
      end
      pwm = 0; enable = 1; rst_n = 1;
      tick();
      tick();

      // Rising phase, delay 3, walking tweak bit.
      p_drive = 8'hA5; n_drive = 8'h5A; tweak_sense = 8'hFF; tweak_delay = 8'd3;
      for (int i = 0; i < 8; i++) tw[i] = 8'(1 << i);
      edge_to(1'b1, 3, "rise d3");
      chk("rise p_out", p_out, 8'hA5);
      chk("rise n_out", n_out, 8'h00);
      chk("rise tweak 0", tweak_out, 8'h01);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("rise tweak walk", tweak_out, 8'(1 << k));
         chk("rise step walk", {5'd0, step}, 8'(k));
      end
      tick();
      chk("rise tweak hold", tweak_out, 8'h80);
      chk("rise step hold", {5'd0, step}, 8'h07);

      // Falling phase, zero delay.
      n_drive = 8'h3C; tweak_sense = 8'h0F; tweak_delay = 8'd0;
      for (int i = 0; i < 8; i++) tw[i] = 8'hFF;
      edge_to(1'b0, 0, "fall d0");
      chk("fall n_out", n_out, 8'h3C);
      chk("fall p_out", p_out, 8'hFF);
      chk("fall tweak_out", tweak_out, 8'h0F);

      // Retrigger mid-DEAD and again at step 4.
      tweak_delay = 8'd10;
      for (int i = 0; i < 8; i++) tw[i] = 8'(8'h11 * (i + 1));
      pwm = 1;
      repeat (6) tick();
      edge_to(1'b0, 10, "retrig dead");
      repeat (4) tick();
      chk("retrig at step 4", {5'd0, step}, 8'h04);
      edge_to(1'b1, 10, "retrig drive");

      // Enable gating from step 5.
      tweak_delay = 8'd2;
      edge_to(1'b0, 2, "enable seq");
      repeat (5) tick();
      chk("enable step 5", {5'd0, step}, 8'h05);
      enable = 0;
      tick();
      chk("disabled active", {7'd0, active}, 8'h00);
      chk("disabled n_out", n_out, 8'h00);
      chk("disabled tweak_out", tweak_out, 8'h00);
      tick();
      chk("disabled active 2", {7'd0, active}, 8'h00);
      enable = 1;
      tick();
      chk("resume active", {7'd0, active}, 8'h01);
      chk("resume step", {5'd0, step}, 8'h07);
      chk("resume tweak", tweak_out, 8'h88 & 8'h0F);

      // Maximum dead time.
      tweak_delay = 8'd255;
      edge_to(1'b1, 255, "delay 255");

      // Reset in the middle of a dead window.
      tweak_delay = 8'd5;
      pwm = 0;
      repeat (3) tick();
      rst_n = 0;
      tick();
      chk("mid reset active", {7'd0, active}, 8'h00);
      chk("mid reset p_out", p_out, 8'hFF);
      rst_n = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post reset idle", {7'd0, active}, 8'h00);
      end

      // Random sweep: the model and overlap checker run every cycle.
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(0, 15) == 0) pwm = ~pwm;
         enable      = ($urandom_range(0, 19) != 0);
         p_drive     = 8'($urandom);
         n_drive     = 8'($urandom);
         tweak_sense = 8'($urandom);
         tweak_delay = 8'($urandom_range(0, 4));
         for (int i = 0; i < 8; i++) tw[i] = 8'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
